// File: rtl/pixel_result_packer.sv
// Converts the two accumulated channel sums to means, applies pedestal and limits,
// and queues tagged 16-bit words in a FIFO. Optional test pattern: PACKER_TESTPAT_EN.
module pixel_result_packer #(
    parameter int ADC_WIDHT  = 14,
    parameter int SUMMER     = 32,
    parameter int SHIFT      = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SUM_VALID,
    input  logic [SUMMER-1:0]    SUM1,
    input  logic [SUMMER-1:0]    SUM2,
    input  logic                 PED_EN,
    input  logic [ADC_WIDHT-1:0] PEDESTAL,
`ifdef PACKER_TESTPAT_EN
    input  logic                 TESTPAT,
`endif
    input  logic                 RD_EN,
    input  logic                 CLR_OVF,
    output logic [15:0]          DATA_OUT,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic [DEPTH_LOG2:0]  LEVEL,
    output logic                 OVERFLOW,
    output logic                 BUSY
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [SUMMER-1:0]    SAT_LIMIT = SUMMER'(1) << ADC_WIDHT;
    localparam logic [ADC_WIDHT-1:0] V_MAX     = '1;

    typedef enum logic [1:0] {IDLE, CALC, WR1, WR2} state_t;

    state_t                 state, state_next;
    logic [SUMMER-1:0]      sum1_r, sum2_r;
    logic [ADC_WIDHT-1:0]   ped_r;
    logic                   ped_en_r;
    logic [ADC_WIDHT-1:0]   res1_val, res2_val;
    logic                   res1_flag, res2_flag;
    logic                   push_req;
    logic [15:0]            push_word;
    logic                   do_read, do_write, ovf_set;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [15:0]            mem [DEPTH];
`ifdef PACKER_TESTPAT_EN
    logic                   testpat_r;
    logic [13:0]            pat_cnt;
`endif

    // Saturation happens on the raw mean, before the pedestal is removed.
    function automatic logic [ADC_WIDHT:0] reduce(input logic [SUMMER-1:0]    s,
                                                  input logic [ADC_WIDHT-1:0] ped,
                                                  input logic                 ped_en);
        logic [SUMMER-1:0]    m;
        logic [ADC_WIDHT-1:0] v;
        logic                 flag;
        m = s >> SHIFT;
        if (m >= SAT_LIMIT) begin
            v    = V_MAX;
            flag = 1'b1;
        end else begin
            v    = m[ADC_WIDHT-1:0];
            flag = 1'b0;
        end
        if (ped_en) begin
            if (v < ped) begin
                v    = '0;
                flag = 1'b1;
            end else begin
                v = v - ped;
            end
        end
        return {flag, v};
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        push_word  = '0;
        case (state)
            IDLE: begin
                if (SUM_VALID) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = WR1;
            end
            WR1: begin
                push_req   = 1'b1;
                push_word  = {1'b0, res1_flag, 14'(res1_val)};
`ifdef PACKER_TESTPAT_EN
                if (testpat_r) begin
                    push_word = {1'b0, 1'b0, pat_cnt};
                end
`endif
                state_next = WR2;
            end
            WR2: begin
                push_req   = 1'b1;
                push_word  = {1'b1, res2_flag, 14'(res2_val)};
`ifdef PACKER_TESTPAT_EN
                if (testpat_r) begin
                    push_word = {1'b1, 1'b0, pat_cnt};
                end
`endif
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sum1_r    <= '0;
            sum2_r    <= '0;
            ped_r     <= '0;
            ped_en_r  <= 1'b0;
            res1_val  <= '0;
            res2_val  <= '0;
            res1_flag <= 1'b0;
            res2_flag <= 1'b0;
`ifdef PACKER_TESTPAT_EN
            testpat_r <= 1'b0;
`endif
        end else begin
            if (state == IDLE && SUM_VALID) begin
                sum1_r   <= SUM1;
                sum2_r   <= SUM2;
                ped_r    <= PEDESTAL;
                ped_en_r <= PED_EN;
`ifdef PACKER_TESTPAT_EN
                testpat_r <= TESTPAT;
`endif
            end
            if (state == CALC) begin
                {res1_flag, res1_val} <= reduce(sum1_r, ped_r, ped_en_r);
                {res2_flag, res2_val} <= reduce(sum2_r, ped_r, ped_en_r);
            end
        end
    end

`ifdef PACKER_TESTPAT_EN
    // Advancing on every push makes the ch2 word carry the ch1 value plus one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pat_cnt <= '0;
        end else if (push_req) begin
            pat_cnt <= pat_cnt + 1'b1;
        end
    end
`endif

    // A push into a full FIFO still lands when a pop frees the slot that cycle.
    assign EMPTY    = (LEVEL == '0);
    assign FULL     = (LEVEL == (DEPTH_LOG2+1)'(DEPTH));
    assign BUSY     = (state != IDLE);
    assign do_read  = RD_EN && !EMPTY;
    assign do_write = push_req && (!FULL || do_read);
    assign ovf_set  = (SUM_VALID && state != IDLE) || (push_req && !do_write);

    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LEVEL    <= '0;
            DATA_OUT <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr   <= rd_ptr + 1'b1;
                DATA_OUT <= mem[rd_ptr];
            end
            case ({do_write, do_read})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
            if (ovf_set) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pixel_result_packer.md
Name: pixel_result_packer

Overview:
- Downstream stage of the dual-channel ADC averager. It consumes the two accumulated sums when an accumulation window closes.
- Per channel: converts the sum to a mean by shifting, optionally subtracts the pedestal, then saturates or clamps the result.
- Packs each channel result into a tagged 16-bit word and buffers the words in a small synchronous FIFO for the readout interface.

Parameters:
- ADC_WIDHT, 14, width of one averaged pixel value.
- SUMMER, 32, width of the SUM1/SUM2 inputs.
- SHIFT, 4, log2 of the samples per window; mean = sum >> SHIFT.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- SUM_VALID  in  1  one-cycle pulse; SUM1/SUM2 are stable and final in this cycle.
- SUM1  in  SUMMER  channel 1 accumulated sum.
- SUM2  in  SUMMER  channel 2 accumulated sum.
- PED_EN  in  1  1 = subtract PEDESTAL from both channels.
- PEDESTAL  in  ADC_WIDHT  pedestal value, sampled together with the sums.
- RD_EN  in  1  FIFO read request.
- CLR_OVF  in  1  clears OVERFLOW.
- DATA_OUT  out  16  word format: [15] channel (0 = ch1, 1 = ch2), [14] limit flag, [13:0] value.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- LEVEL  out  DEPTH_LOG2+1  current word count.
- OVERFLOW  out  1  sticky; set when data is lost.
- BUSY  out  1  state machine not in IDLE.

Behaviour:
- Reset values (RESET low, asynchronous): DATA_OUT=0, EMPTY=1, FULL=0, LEVEL=0, OVERFLOW=0, BUSY=0. Read/write pointers are 0 and the FSM is in IDLE.
- FSM states: IDLE, CALC, WR1, WR2.
  - IDLE: on SUM_VALID, register SUM1, SUM2, PEDESTAL and PED_EN, then go to CALC.
  - CALC (1 cycle): per channel compute m = s >> SHIFT.
    - If m >= 2**ADC_WIDHT: v = 2**ADC_WIDHT-1, flag = 1.
    - If PED_EN and v < ped: v = 0, flag = 1. Otherwise v = v - ped (only when PED_EN).
    - Saturation is applied before subtraction. Results are registered. Go to WR1.
  - WR1: push {1'b0, flag1, v1}, go to WR2.
  - WR2: push {1'b1, flag2, v2}, go to IDLE.
- Latency: SUM_VALID sampled at edge n gives ch1 written at edge n+2 and ch2 at edge n+3. EMPTY falls after edge n+2 when the FIFO was empty.
- BUSY = 1 in CALC, WR1 and WR2.
- SUM_VALID while BUSY: the window is discarded, OVERFLOW is set, and the FSM is unaffected.
- Push when FULL: the word is dropped and OVERFLOW is set. Exception: if RD_EN is also asserted that cycle, read and write both proceed and LEVEL is unchanged.
- Read: RD_EN with EMPTY=0 pops the word. DATA_OUT is registered and valid the cycle after RD_EN (not first-word-fall-through). DATA_OUT holds its last value otherwise. RD_EN while EMPTY is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: LEVEL is unchanged.
- Pointers wrap modulo depth. FULL = (LEVEL == depth), EMPTY = (LEVEL == 0).
- OVERFLOW clear: CLR_OVF clears it the next cycle. If a set condition occurs in the same cycle, set wins.
- Words are never partially written. A FIFO full on WR1 but freed by WR2 stores only the ch2 word.

Optional Feature:
- Macro: PACKER_TESTPAT_EN.
- Defined: adds input port TESTPAT (1 bit). When TESTPAT=1 at capture, v1 and v2 are replaced by a 14-bit free-running pattern counter.
  - The counter increments once per pushed word, and ch2 uses ch1's value +1. Flag is 0.
  - The counter resets to 0 and wraps 16383 -> 0.
- Undefined: no TESTPAT port, no counter; behaviour as above.

Test Plan:
- PED_EN=1, PEDESTAL=100, SUM1=0x1000, SUM2=0x50, SUM_VALID pulse -> words 0x009C then 0xC000 (ch2 clamped). LEVEL=2 after edge n+3.
- PED_EN=0, SUM1=0x0010_0000, SUM2=0x3FFF0 -> 0x7FFF (saturated) then 0xBFFF (ch2 = 16383, flag 0).
- 8 windows without reads -> FULL=1, LEVEL=16. 9th window -> both words dropped, OVERFLOW=1. CLR_OVF -> OVERFLOW=0 next cycle.
- Second SUM_VALID one cycle after the first -> only one word pair stored, OVERFLOW=1, BUSY high for 3 cycles.
- FIFO full with RD_EN held during WR1 -> ch1 word stored, LEVEL stays 16, first stored word on DATA_OUT the next cycle.
- Assert RESET low during WR1 -> all outputs return to reset values immediately. After release, a new window produces a clean pair starting at LEVEL 0.
